// File: rtl/seq_stim_gen.sv
// seq_stim_gen: serial stimulus source for the consecutive-ones detector.
// Shifts a latched pattern out on `a` (LSB first). The pattern can repeat,
// with forced-zero gaps between repetitions, under a start/busy/done handshake.
// It also counts the detector's out1 rising edges and its out2-high samples.
module seq_stim_gen #(
  parameter int WIDTH   = 16,
  parameter int LEN_W   = $clog2(WIDTH + 1),
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       reps,
  input  logic             out1,
  input  logic             out2,
  output logic             a,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fin_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYC - 1);
  localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state;
  logic [WIDTH-1:0] pat;       // latched pattern, reloaded at every repetition
  logic [WIDTH-1:0] shreg;     // bits still to be shifted in this repetition
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bits_left; // bits remaining after the one now on `a`
  logic [3:0]       reps_left; // repetitions remaining, including the current one
  logic [GAP_W-1:0] gap_cnt;
  logic             hist;      // previous out1 sample, for edge detection

  logic [LEN_W-1:0] len_clamp;
  logic [3:0]       reps_eff;

  // Normalise the job request: clamp the length, and treat reps=0 as one pass.
  always_comb begin
    len_clamp = (len > WIDTH_L) ? WIDTH_L : len;
    reps_eff  = (reps == 4'd0) ? 4'd1 : reps;
  end

  // Sequencer: IDLE -> SHIFT (-> GAP -> SHIFT)* -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pat       <= '0;
      shreg     <= '0;
      len_q     <= '0;
      bits_left <= '0;
      reps_left <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          a    <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            pat       <= pattern;
            len_q     <= len_clamp;
            reps_left <= reps_eff;
            if (len_clamp != '0) begin
              state     <= S_SHIFT;
              a         <= pattern[0];
              shreg     <= pattern >> 1;
              bits_left <= len_clamp - LEN_W'(1);
              busy      <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          if (bits_left == '0) begin
            a <= 1'b0;
            if (reps_left > 4'd1) begin
              state     <= S_GAP;
              reps_left <= reps_left - 4'd1;
              gap_cnt   <= GAP_INIT;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            a         <= shreg[0];
            shreg     <= shreg >> 1;
            bits_left <= bits_left - LEN_W'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state     <= S_SHIFT;
            a         <= pat[0];
            shreg     <= pat >> 1;
            bits_left <= len_q - LEN_W'(1);
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          a     <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          a     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Detection counters. Sampling continues through DONE so that the
  // detector's one-cycle lag on the final bit is still counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_cnt <= '0;
      fin_cnt  <= '0;
      hist     <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        rise_cnt <= '0;
        fin_cnt  <= '0;
        hist     <= 1'b0;
      end
    end else begin
      hist <= out1;
      if (out1 && !hist && (rise_cnt != CNT_MAX))
        rise_cnt <= rise_cnt + CNT_W'(1);
      if (out2 && (fin_cnt != CNT_MAX))
        fin_cnt <= fin_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_stim_gen.sv
// tb_seq_stim_gen: drives seq_stim_gen into a behavioural consecutive-ones
// detector. The expected `a` stream and the counter values are derived from
// the run lengths of ones in that stream. A CNT_W=4 copy covers saturation.
module tb_seq_stim_gen;
  localparam int WIDTH   = 16;
  localparam int GAP_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  len = '0;
  logic [3:0]  reps = '0;
  logic        out1, out2;
  logic        a, busy, done;
  logic [7:0]  rise_cnt, fin_cnt;
  logic        a4, busy4, done4;
  logic [3:0]  rise4, fin4;
  logic [1:0]  det;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_a[$];
  int exp_rise, exp_fin;

  seq_stim_gen #(.WIDTH(WIDTH), .GAP_CYC(GAP_CYC), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .out1(out1), .out2(out2), .a(a), .busy(busy), .done(done),
    .rise_cnt(rise_cnt), .fin_cnt(fin_cnt));

  seq_stim_gen #(.WIDTH(WIDTH), .GAP_CYC(GAP_CYC), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .len(len),
    .reps(reps), .out1(out1), .out2(out2), .a(a4), .busy(busy4), .done(done4),
    .rise_cnt(rise4), .fin_cnt(fin4));

  always #5 clk = ~clk;

  // Consecutive-ones detector: 0 = no ones, 1 = one in a row, 2 = two or more.
  always @(posedge clk) begin
    if (!rst_n)      det <= 2'd0;
    else if (!a)     det <= 2'd0;
    else if (det == 2'd0) det <= 2'd1;
    else             det <= 2'd2;
  end
  assign out1 = (det == 2'd1);
  assign out2 = (det == 2'd2);

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: the stream is len bits per pass, with GAP_CYC zeros between passes.
  // The detector seen at sample c reflects the trailing run of ones after c stream bits.
  task automatic model(input logic [15:0] p, input int l, input int r);
    int le, re, run, raw_r, raw_f;
    bit p1, o1;
    exp_a.delete();
    le = (l > WIDTH) ? WIDTH : l;
    re = (r == 0) ? 1 : r;
    if (le != 0)
      for (int k = 0; k < re; k++) begin
        for (int i = 0; i < le; i++) exp_a.push_back(p[i]);
        if (k < re - 1) repeat (GAP_CYC) exp_a.push_back(1'b0);
      end
    run = 0; p1 = 1'b0; raw_r = 0; raw_f = 0;
    for (int c = 0; c <= exp_a.size(); c++) begin
      if (c > 0) run = exp_a[c-1] ? run + 1 : 0;
      o1 = (run == 1);
      if (o1 && !p1) raw_r++;
      if (run >= 2) raw_f++;
      p1 = o1;
    end
    exp_rise = raw_r;
    exp_fin  = raw_f;
  endtask

  // Launch a job at the next edge, then check every cycle through DONE -> IDLE.
  task automatic run_job(input logic [15:0] p, input int l, input int r,
                         input bit hold, input string tag);
    model(p, l, r);
    pattern = p; len = 5'(l); reps = 4'(r); start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    pattern = 16'($urandom); len = 5'($urandom); reps = 4'($urandom);
    for (int k = 0; k < exp_a.size(); k++) begin
      chk({tag, " a"}, a, exp_a[k]);
      chk({tag, " busy"}, busy, 1);
      chk({tag, " done"}, done, 0);
      @(posedge clk); #1;
    end
    chk({tag, " end a"}, a, 0);
    chk({tag, " end busy"}, busy, 0);
    chk({tag, " end done"}, done, 1);
    @(posedge clk); #1;
    chk({tag, " idle done"}, done, 0);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " rise"}, rise_cnt, sat(exp_rise, 255));
    chk({tag, " fin"}, fin_cnt, sat(exp_fin, 255));
    chk({tag, " rise4"}, rise4, sat(exp_rise, 15));
    chk({tag, " fin4"}, fin4, sat(exp_fin, 15));
  endtask

  initial begin
    logic [15:0] rp;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst a", a, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rise", rise_cnt, 0);
    chk("rst fin", fin_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(16'h0007, 3, 1, 1'b0, "t_111");
    chk("t_111 plan rise", rise_cnt, 1);
    chk("t_111 plan fin", fin_cnt, 2);

    run_job(16'h0005, 4, 1, 1'b0, "t_0101");
    chk("t_0101 plan rise", rise_cnt, 2);
    chk("t_0101 plan fin", fin_cnt, 0);

    run_job(16'h0003, 2, 3, 1'b0, "t_rep3");
    chk("t_rep3 plan rise", rise_cnt, 3);
    chk("t_rep3 plan fin", fin_cnt, 3);

    run_job(16'hBEEF, 0, 1, 1'b0, "t_len0");
    chk("t_len0 plan rise", rise_cnt, 0);

    run_job(16'hFFFF, 16, 15, 1'b0, "t_full");
    chk("t_full plan rise", rise_cnt, 15);
    chk("t_full plan fin", fin_cnt, 225);
    chk("t_full plan rise4", rise4, 15);
    chk("t_full plan fin4", fin4, 15);

    run_job(16'hA5C3, 25, 2, 1'b0, "t_clamp");
    run_job(16'h00F6, 7, 0, 1'b0, "t_reps0");
    run_job(16'h3C3C, 9, 2, 1'b1, "t_hold");
    run_job(16'h0F0F, 12, 1, 1'b0, "t_after_hold");

    // Abort a len=10 job after bit 5 with start held high.
    rp = 16'h03FF;
    model(rp, 10, 1);
    pattern = rp; len = 5'd10; reps = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= 5; k++) begin
      chk("t_abort a", a, exp_a[k]);
      @(posedge clk); #1;
    end
    // The loop consumed one extra edge; the job is now on bit 6. Reset there.
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t_abort a", a, 0);
    chk("t_abort busy", busy, 0);
    chk("t_abort done", done, 0);
    chk("t_abort rise", rise_cnt, 0);
    chk("t_abort fin", fin_cnt, 0);
    rst_n = 1'b1;
    run_job(16'h0036, 6, 2, 1'b0, "t_relaunch");

    for (int j = 0; j < 25; j++) begin
      run_job(16'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
              bit'($urandom_range(0, 1)), "t_rand");
    end

    start = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
